// File: rtl/micro_ucr_hash_multi.sv
// micro_ucr_hash_multi: multi-channel nonce search over the micro UCR hash.
// Optional feature macro: HASH_CONTADOR_INTENTOS_EN enables the intentos counter.
//
// Hash of (bloque_datos, nonce):
//   W[0..11]  = block bytes, MSB first.
//   W[12..15] = nonce zero-extended to 32 bits, MSB first.
//   W[16..31] = W[j-3] | (W[j-9] ^ W[j-14]).
//   Initial values: a=01, b=89, c=FE.
//   Rounds j=0..31: k=99, x=a^b for j<=16; k=A1, x=a^b^c otherwise.
//   Each round: a'=b^c, b'=c<<4, c'=x+k+W[j].
//   Result: {01+a, 89+b, FE+c}.
// Hit rule: hash[23:16] < target, with target FF accepting any hash.
//
// Pipeline:
//   issue stage    -> registered nonces and valids of the step.
//   result stage   -> registered hash and hit per channel.
//   winner capture -> one more edge.
//
// state      | meaning
// IDLE       | after reset, waiting for inicio
// BUSCAR     | issuing steps and watching for hits
// ENCONTRADO | winner held in bounty / nonce_ganador
// AGOTADO    | range exhausted without a hit

module micro_ucr_hash_multi #(
    parameter int NUM_NUCLEOS = 4,
    parameter int ANCHO_NONCE = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   inicio,
    input  logic [95:0]            bloque_datos,
    input  logic [ANCHO_NONCE-1:0] nonce_inicial,
    input  logic [ANCHO_NONCE-1:0] nonce_limite,
    input  logic [7:0]             target,
    output logic [23:0]            bounty,
    output logic [ANCHO_NONCE-1:0] nonce_ganador,
    output logic                   terminado,
    output logic                   agotado,
    output logic                   ocupado,
    output logic [31:0]            intentos
);

    typedef enum logic [1:0] {IDLE, BUSCAR, ENCONTRADO, AGOTADO} estado_t;

    estado_t estado, estado_sig;

    logic [95:0]            blk_q;
    logic [ANCHO_NONCE-1:0] lim_q;
    logic [7:0]             tgt_q;
    logic [ANCHO_NONCE:0]   base_q;

    logic                   emitido_q;
    logic [NUM_NUCLEOS-1:0] emit_valid_q;
    logic [ANCHO_NONCE-1:0] emit_nonce_q [NUM_NUCLEOS];

    logic [NUM_NUCLEOS-1:0] res_hit_q;
    logic [23:0]            res_hash_q  [NUM_NUCLEOS];
    logic [ANCHO_NONCE-1:0] res_nonce_q [NUM_NUCLEOS];

    logic [NUM_NUCLEOS-1:0] paso_valid;
    logic [ANCHO_NONCE-1:0] paso_nonce [NUM_NUCLEOS];
    logic [NUM_NUCLEOS-1:0] hit_c;
    logic [23:0]            hash_c [NUM_NUCLEOS];
    logic [23:0]            gan_hash;
    logic [ANCHO_NONCE-1:0] gan_nonce;
    logic                   cargar, emitir, ganar, agotar, hay_hit, sin_canales;

    function automatic logic [23:0] micro_hash(input logic [95:0] blk, input logic [31:0] n);
        logic [7:0] w [32];
        logic [7:0] a, b, c, x, k, a_n, b_n;
        for (int j = 0; j < 12; j++) w[j] = blk[95-8*j -: 8];
        for (int j = 0; j < 4; j++) w[12+j] = n[31-8*j -: 8];
        for (int j = 16; j < 32; j++) w[j] = w[j-3] | (w[j-9] ^ w[j-14]);
        a = 8'h01;
        b = 8'h89;
        c = 8'hFE;
        for (int j = 0; j < 32; j++) begin
            if (j <= 16) begin
                k = 8'h99;
                x = a ^ b;
            end else begin
                k = 8'hA1;
                x = a ^ b ^ c;
            end
            a_n = b ^ c;
            b_n = c << 4;
            c   = x + k + w[j];
            a   = a_n;
            b   = b_n;
        end
        return {8'h01 + a, 8'h89 + b, 8'hFE + c};
    endfunction

    // Nonces of the next step; the extra sum bit catches wrap past the top.
    always_comb begin
        logic [ANCHO_NONCE:0] suma;
        suma = '0;
        for (int i = 0; i < NUM_NUCLEOS; i++) begin
            suma          = base_q + (ANCHO_NONCE+1)'(i);
            paso_nonce[i] = suma[ANCHO_NONCE-1:0];
            paso_valid[i] = !suma[ANCHO_NONCE] && (suma[ANCHO_NONCE-1:0] <= lim_q);
        end
    end

    // Per-channel hash datapath on the issued step.
    always_comb begin
        for (int i = 0; i < NUM_NUCLEOS; i++) begin
            hash_c[i] = micro_hash(blk_q, 32'(emit_nonce_q[i]));
            hit_c[i]  = emit_valid_q[i] && ((hash_c[i][23:16] < tgt_q) || (tgt_q == 8'hFF));
        end
    end

    // Lowest channel index with a registered hit wins.
    always_comb begin
        gan_hash  = '0;
        gan_nonce = '0;
        for (int i = NUM_NUCLEOS-1; i >= 0; i--) begin
            if (res_hit_q[i]) begin
                gan_hash  = res_hash_q[i];
                gan_nonce = res_nonce_q[i];
            end
        end
    end

    assign hay_hit     = |res_hit_q;
    assign sin_canales = emitido_q && (emit_valid_q == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) estado <= IDLE;
        else          estado <= estado_sig;
    end

    // Next state and control strobes; a hit in flight beats exhaustion.
    always_comb begin
        estado_sig = estado;
        cargar     = 1'b0;
        emitir     = 1'b0;
        ganar      = 1'b0;
        agotar     = 1'b0;
        unique case (estado)
            IDLE, ENCONTRADO, AGOTADO: begin
                if (inicio) begin
                    cargar     = 1'b1;
                    estado_sig = BUSCAR;
                end
            end
            BUSCAR: begin
                if (inicio) begin
                    cargar     = 1'b1;
                    estado_sig = BUSCAR;
                end else if (hay_hit) begin
                    ganar      = 1'b1;
                    estado_sig = ENCONTRADO;
                end else if (sin_canales) begin
                    agotar     = 1'b1;
                    estado_sig = AGOTADO;
                end else begin
                    emitir = 1'b1;
                end
            end
            default: estado_sig = IDLE;
        endcase
    end

    // Job latch, issue/result pipeline and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blk_q         <= '0;
            lim_q         <= '0;
            tgt_q         <= '0;
            base_q        <= '0;
            emitido_q     <= 1'b0;
            emit_valid_q  <= '0;
            res_hit_q     <= '0;
            bounty        <= '0;
            nonce_ganador <= '0;
            for (int i = 0; i < NUM_NUCLEOS; i++) begin
                emit_nonce_q[i] <= '0;
                res_hash_q[i]   <= '0;
                res_nonce_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_NUCLEOS; i++) begin
                emit_nonce_q[i] <= paso_nonce[i];
                res_hash_q[i]   <= hash_c[i];
                res_nonce_q[i]  <= emit_nonce_q[i];
            end
            emitido_q    <= emitir;
            emit_valid_q <= emitir ? paso_valid : '0;
            res_hit_q    <= (cargar || ganar || agotar) ? '0 : hit_c;
            if (emitir) base_q <= base_q + (ANCHO_NONCE+1)'(NUM_NUCLEOS);
            if (cargar) begin
                blk_q         <= bloque_datos;
                lim_q         <= nonce_limite;
                tgt_q         <= target;
                base_q        <= {1'b0, nonce_inicial};
                bounty        <= '0;
                nonce_ganador <= '0;
            end else if (ganar) begin
                bounty        <= gan_hash;
                nonce_ganador <= gan_nonce;
            end else if (agotar) begin
                bounty        <= '0;
                nonce_ganador <= '0;
            end
        end
    end

    assign ocupado   = (estado == BUSCAR);
    assign terminado = (estado == ENCONTRADO);
    assign agotado   = (estado == AGOTADO);

`ifdef HASH_CONTADOR_INTENTOS_EN
    logic [31:0] intentos_q;
    logic [3:0]  n_validos;

    // Number of live channels in the step about to be issued.
    always_comb begin
        n_validos = '0;
        for (int i = 0; i < NUM_NUCLEOS; i++) n_validos = n_validos + 4'(paso_valid[i]);
    end

    // Saturating count of evaluated nonces for the current job.
    always_ff @(posedge clk) begin
        logic [32:0] suma_int;
        suma_int = {1'b0, intentos_q} + 33'(n_validos);
        if (!reset_n)    intentos_q <= '0;
        else if (cargar) intentos_q <= '0;
        else if (emitir) intentos_q <= suma_int[32] ? 32'hFFFF_FFFF : suma_int[31:0];
    end

    assign intentos = intentos_q;
`else
    assign intentos = '0;
`endif

endmodule

// File: tb/tb_micro_ucr_hash_multi.sv
// Randomized self-checking bench for micro_ucr_hash_multi (default parameters).
module tb_micro_ucr_hash_multi;

    localparam int NN = 4;
`ifdef HASH_CONTADOR_INTENTOS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        inicio = 1'b0;
    logic [95:0] bloque_datos = '0;
    logic [31:0] nonce_inicial = '0;
    logic [31:0] nonce_limite = '0;
    logic [7:0]  target = '0;
    logic [23:0] bounty;
    logic [31:0] nonce_ganador;
    logic        terminado, agotado, ocupado;
    logic [31:0] intentos;

    micro_ucr_hash_multi #(.NUM_NUCLEOS(NN), .ANCHO_NONCE(32)) dut (
        .clk(clk), .reset_n(reset_n), .inicio(inicio), .bloque_datos(bloque_datos),
        .nonce_inicial(nonce_inicial), .nonce_limite(nonce_limite), .target(target),
        .bounty(bounty), .nonce_ganador(nonce_ganador), .terminado(terminado),
        .agotado(agotado), .ocupado(ocupado), .intentos(intentos)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;
    int job_edge = 0;
    int mode = 0;           // 0 no check, 1 job running/held, 2 everything zero
    int jcyc;
    string tag = "";

    bit          e_found;
    longint      e_win;
    int          e_hash;
    longint      e_int;
    int          e_lat;
    logic [90:0] got, req;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Reference hash written with plain integer arithmetic.
    function automatic int model_hash(input bit [95:0] blk, input bit [31:0] n);
        int w[32];
        int a, b, c, x, k, an, bn;
        for (int j = 0; j < 12; j++) w[j] = int'((blk >> (88 - 8*j)) & 96'hFF);
        for (int j = 0; j < 4; j++) w[12+j] = int'((n >> (24 - 8*j)) & 32'hFF);
        for (int j = 16; j < 32; j++) w[j] = w[j-3] | (w[j-9] ^ w[j-14]);
        a = 1; b = 137; c = 254;
        for (int j = 0; j < 32; j++) begin
            if (j <= 16) begin k = 153; x = a ^ b; end
            else begin k = 161; x = a ^ b ^ c; end
            an = b ^ c;
            bn = (c * 16) % 256;
            c  = (x + k + w[j]) % 256;
            a  = an;
            b  = bn;
        end
        return (((a + 1) % 256) << 16) | (((b + 137) % 256) << 8) | ((c + 254) % 256);
    endfunction

    function automatic bit model_hit(input int h, input int tgt);
        return ((h >> 16) < tgt) || (tgt == 255);
    endfunction

    // Whole-job outcome from the search rules: first hitting nonce in order,
    // steps of NN nonces, one step in flight behind the winner.
    task automatic model_job(input bit [95:0] blk, input longint ini, input longint lim, input int tgt,
                             output bit found, output longint win, output int hsh,
                             output longint cnt_int, output int lat);
        longint cnt, k, lastn;
        cnt = (lim >= ini) ? (lim - ini + 1) : 0;
        found = 0; win = 0; hsh = 0;
        for (longint n = ini; n <= lim && !found; n++) begin
            if (model_hit(model_hash(blk, n[31:0]), tgt)) begin
                found = 1; win = n; hsh = model_hash(blk, n[31:0]);
            end
        end
        if (found) begin
            k = (win - ini) / NN;
            lat = int'(k) + 3;
            lastn = (k + 2) * NN;
            cnt_int = (cnt < lastn) ? cnt : lastn;
        end else begin
            lat = int'((cnt + NN - 1) / NN) + 2;
            cnt_int = cnt;
        end
    endtask

    task automatic pin(input string name, input longint actual, input longint required);
        n_tests++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    // One compare process: every cycle while a job or reset expectation is active.
    always @(negedge clk) begin
        if (mode == 1) begin
            jcyc = edge_no - job_edge;
            n_tests++;
            if (jcyc < e_lat) begin
                if ({ocupado, terminado, agotado} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL %s search cycle %0d: ocupado/terminado/agotado=%b required 100",
                             tag, jcyc, {ocupado, terminado, agotado});
                end
            end else begin
                got = {ocupado, terminado, agotado, bounty, nonce_ganador, intentos};
                req = {1'b0, e_found, !e_found,
                       e_found ? e_hash[23:0] : 24'h0,
                       e_found ? e_win[31:0] : 32'h0,
                       CNT_EN ? e_int[31:0] : 32'h0};
                if (got !== req) begin
                    n_fail++;
                    $display("FAIL %s result cycle %0d: flags=%b bounty=%h nonce=%h intentos=%0d required flags=%b bounty=%h nonce=%h intentos=%0d",
                             tag, jcyc, got[90:88], got[87:64], got[63:32], got[31:0],
                             req[90:88], req[87:64], req[63:32], req[31:0]);
                end
            end
        end else if (mode == 2) begin
            n_tests++;
            got = {ocupado, terminado, agotado, bounty, nonce_ganador, intentos};
            if (got !== '0) begin
                n_fail++;
                $display("FAIL %s idle: outputs=%h required all zero", tag, got);
            end
        end
    end

    task automatic scribble();
        bloque_datos  = {$urandom, $urandom, $urandom};
        nonce_inicial = $urandom;
        nonce_limite  = $urandom;
        target        = 8'($urandom);
    endtask

    task automatic run_wait(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            scribble();
        end
    endtask

    task automatic do_reset(input int n, input bit with_inicio, input string name);
        @(negedge clk);
        reset_n = 1'b0;
        inicio  = with_inicio;
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
        inicio  = 1'b0;
        tag     = name;
        mode    = 2;
    endtask

    task automatic start_job(input bit [95:0] blk, input longint ini, input longint lim,
                             input int tgt, input string name);
        bit f; longint w; int h; longint ci; int l;
        model_job(blk, ini, lim, tgt, f, w, h, ci, l);
        @(negedge clk);
        bloque_datos  = blk;
        nonce_inicial = ini[31:0];
        nonce_limite  = lim[31:0];
        target        = tgt[7:0];
        inicio        = 1'b1;
        @(posedge clk);
        #1;
        inicio   = 1'b0;
        e_found  = f; e_win = w; e_hash = h; e_int = ci; e_lat = l;
        job_edge = edge_no;
        tag      = name;
        mode     = 1;
    endtask

    initial begin
        bit [95:0] blk;
        int t[7];
        int mx, mn, tgt;
        bit ok;
        longint ini, lim;

        do_reset(2, 1'b0, "reset");
        run_wait(3);

        // Accept-all target: nonce_inicial wins after three edges.
        blk = {$urandom, $urandom, $urandom};
        start_job(blk, 0, 1000, 255, "first_nonce");
        pin("first_nonce_lat", e_lat, 3);
        pin("first_nonce_win", e_win, 0);
        pin("first_nonce_found", e_found, 1);
        run_wait(e_lat + 3);

        start_job(blk, 100, 109, 0, "exhaust_10");
        pin("exhaust_10_int", e_int, 10);
        pin("exhaust_10_lat", e_lat, 5);
        run_wait(e_lat + 3);

        // Find a block where nonces 5 and 6 hit but 0..4 miss.
        ok = 0;
        for (int tries = 0; tries < 20000 && !ok; tries++) begin
            blk = {$urandom, $urandom, $urandom};
            for (int n = 0; n < 7; n++) t[n] = model_hash(blk, n) >> 16;
            mx = (t[5] > t[6]) ? t[5] : t[6];
            mn = 255;
            for (int n = 0; n < 5; n++) if (t[n] < mn) mn = t[n];
            if (mx < mn && mx + 1 < 255) begin ok = 1; tgt = mx + 1; end
        end
        pin("tie_block_found", ok, 1);
        if (ok) begin
            start_job(blk, 0, 100, tgt, "two_hits");
            pin("two_hits_win", e_win, 5);
            pin("two_hits_lat", e_lat, 4);
            pin("two_hits_int", e_int, 12);
            run_wait(e_lat + 3);
        end

        start_job(blk, 64'hFFFF_FFFE, 64'hFFFF_FFFF, 0, "top_of_range");
        pin("top_of_range_int", e_int, 2);
        pin("top_of_range_lat", e_lat, 3);
        run_wait(e_lat + 3);

        start_job(blk, 50, 49, 0, "empty_range");
        pin("empty_range_int", e_int, 0);
        pin("empty_range_lat", e_lat, 2);
        run_wait(e_lat + 3);

        // Restart during search: only the second job may report.
        start_job(blk, 0, 5000, 0, "abort_first");
        run_wait(3);
        start_job(blk, 500, 600, 255, "abort_second");
        pin("abort_second_win", e_win, 500);
        run_wait(e_lat + 3);

        // Reset mid-search, then a clean job.
        start_job(blk, 0, 5000, 0, "doomed");
        run_wait(4);
        do_reset(1, 1'b0, "reset_mid");
        run_wait(5);
        start_job(blk, 7, 20, 255, "after_reset");
        pin("after_reset_win", e_win, 7);
        run_wait(e_lat + 3);

        // Reset beats a simultaneous inicio.
        do_reset(1, 1'b1, "reset_vs_inicio");
        run_wait(4);

        for (int r = 0; r < 30; r++) begin
            blk = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       ini = 64'hFFFF_FFF0 + $urandom_range(0, 15);
                default: ini = longint'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0 && ini > 20) lim = ini - 1 - $urandom_range(0, 10);
            else begin
                lim = ini + $urandom_range(0, 40);
                if (lim > 64'hFFFF_FFFF) lim = 64'hFFFF_FFFF;
            end
            case ($urandom_range(0, 3))
                0:       tgt = 0;
                1:       tgt = $urandom_range(0, 15);
                2:       tgt = $urandom_range(0, 255);
                default: tgt = 255;
            endcase
            start_job(blk, ini, lim, tgt, $sformatf("rand_%0d", r));
            run_wait(e_lat + 3);
        end

        mode = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/micro_ucr_hash_multi.md
MICRO_UCR_HASH_MULTI -- requirements
Module: micro_ucr_hash_multi

Interface
REQ-001 Parameter NUM_NUCLEOS, default 4, number of parallel hash channels (legal 1..8).
REQ-002 Parameter ANCHO_NONCE, default 32, nonce width in bits (legal 16..32).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 inicio  input  1  one-cycle start pulse; latches job inputs.
REQ-006 bloque_datos  input  96  fixed data block hashed with each nonce.
REQ-007 nonce_inicial  input  ANCHO_NONCE  first nonce of the search.
REQ-008 nonce_limite  input  ANCHO_NONCE  last nonce allowed, inclusive.
REQ-009 target  input  8  difficulty target for the team hit rule.
REQ-010 bounty  output  24  hash of the winning nonce.
REQ-011 nonce_ganador  output  ANCHO_NONCE  winning nonce.
REQ-012 terminado  output  1  high while a winning result is held.
REQ-013 agotado  output  1  high while a no-hit result is held.
REQ-014 ocupado  output  1  high while searching.
REQ-015 intentos  output  32  count of nonces evaluated (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, BUSCAR, ENCONTRADO and AGOTADO.
REQ-017 In IDLE, inicio SHALL latch bloque_datos, nonce_inicial, nonce_limite and target, then move to BUSCAR.
REQ-018 In BUSCAR, search step k SHALL give channel i the nonce nonce_inicial + k*NUM_NUCLEOS + i.
REQ-019 Nonce sum SHALL use ANCHO_NONCE+1 bits; a carry-out or sum > nonce_limite SHALL mask that channel as not evaluated.
REQ-020 Each channel SHALL compute the 24-bit hash with the team hash datapath (block load, W generation, hash rounds, target compare).
REQ-021 Each channel SHALL register hash and hit in one pipeline stage; the step issued at cycle t has its result at cycle t+1.
REQ-022 Winner SHALL be the lowest channel index with a registered hit; earlier steps always win over later ones.
REQ-023 On a registered hit, the next edge SHALL load bounty and nonce_ganador, enter ENCONTRADO and drop in-flight results.
REQ-024 Search latency: a hit on nonce_inicial (step 0, channel 0) SHALL assert terminado 3 cycles after the inicio edge.
REQ-025 When all channels of an issued step are masked and the pipeline holds no hit, the FSM SHALL enter AGOTADO.
REQ-026 In AGOTADO, bounty and nonce_ganador SHALL be 0.
REQ-027 ocupado SHALL be 1 only in BUSCAR; terminado only in ENCONTRADO; agotado only in AGOTADO.
REQ-028 ENCONTRADO and AGOTADO SHALL hold their outputs until the next inicio, which starts a new job directly.
REQ-029 inicio during BUSCAR SHALL abort the current job and restart with the newly latched inputs.
REQ-030 nonce_limite < nonce_inicial SHALL reach AGOTADO with zero nonces evaluated.
REQ-031 Job inputs SHALL be ignored when inicio is low.

Reset
REQ-032 reset_n=0 at an edge SHALL force IDLE and set bounty, nonce_ganador, terminado, agotado, ocupado, intentos and the pipeline valids to 0.
REQ-033 Reset SHALL win over a simultaneous inicio.
REQ-034 Reset mid-search SHALL discard the job; no result SHALL be flagged afterwards.

Configuration
REQ-035 With HASH_CONTADOR_INTENTOS_EN defined, intentos SHALL:
- clear on inicio;
- add the number of unmasked channels per issued step;
- saturate at 32'hFFFFFFFF;
- hold in ENCONTRADO and AGOTADO.
REQ-036 With HASH_CONTADOR_INTENTOS_EN undefined, intentos SHALL be constant 0 and no counter logic SHALL be built.

Verification
REQ-037 NUM_NUCLEOS=4, target=8'hFF, nonce_inicial=0 -> terminado 3 cycles after inicio, nonce_ganador=0, bounty equals the reference-model hash of nonce 0.
REQ-038 target=8'h00, nonce_inicial=100, nonce_limite=109 -> agotado asserts, bounty=0, nonce_ganador=0; intentos=10 if macro defined.
REQ-039 Reference model picks a target where nonces 5 and 6 both hit and 0..4 miss -> nonce_ganador=5 (channel 1 of step 1).
REQ-040 nonce_inicial=32'hFFFFFFFE, nonce_limite=32'hFFFFFFFF, target=8'h00 -> agotado, no wrap to nonce 0, intentos=2 if macro defined.
REQ-041 reset_n low for 1 cycle during BUSCAR -> all outputs 0 next cycle and IDLE; a later inicio runs a clean job.
REQ-042 Second inicio during BUSCAR with a new nonce_inicial -> result matches only the second job.
